// File: rtl/rs_dec_mon_if.sv
// Decoded-word stream between the RS decoder and its monitor: the decoder
// side drives dec_*/rde_error, the monitor returns a registered copy on out_*.
interface rs_dec_mon_if;
    logic        dec_vld;
    logic [63:0] dec_data;
    logic        dec_isos;
    logic        rde_error;
    logic        out_vld;
    logic [63:0] out_data;
    logic        out_isos;

    modport master (
        output dec_vld, dec_data, dec_isos, rde_error,
        input  out_vld, out_data, out_isos
    );

    modport slave (
        input  dec_vld, dec_data, dec_isos, rde_error,
        output out_vld, out_data, out_isos
    );
endinterface

// File: rtl/rs_dec_mon.sv
// RS decoder output monitor: one-cycle passthrough of the decoded stream plus
// codeword/failure statistics feeding a windowed link-health state machine.
module rs_dec_mon #(
    parameter int WORDS_PER_CW = 24,
    parameter int WIN_CW       = 1024,
    parameter int FAIL_TH      = 4,
    parameter int RECOVER_WIN  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rs_ena,
    input  logic        clr_stats,
    rs_dec_mon_if.slave bus,
    output logic [31:0] cw_cnt,
    output logic [15:0] fail_cnt,
    output logic [15:0] isos_cnt,
    output logic [1:0]  link_state,
    output logic        link_degrade,
    output logic        link_fail_irq
);
    localparam int BEAT_W = (WORDS_PER_CW > 1) ? $clog2(WORDS_PER_CW) : 1;
    localparam int WCW_W  = (WIN_CW > 1) ? $clog2(WIN_CW) : 1;
    localparam int WFL_W  = $clog2(FAIL_TH + 1);
    localparam int CLN_W  = $clog2(RECOVER_WIN + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MON = 2'd1, ST_DEGR = 2'd2, ST_FAIL = 2'd3} state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != '1)) ? v + 16'd1 : v;
    endfunction

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               cw_fail_q, cw_fail_d;
    logic [WCW_W-1:0]   win_cw_q, win_cw_d;
    logic [WFL_W-1:0]   win_fail_q, win_fail_d, win_fail_nxt;
    logic [CLN_W-1:0]   clean_q, clean_d;
    logic [31:0]        cw_cnt_q, cw_cnt_d;
    logic [15:0]        fail_cnt_q, fail_cnt_d;
    logic [15:0]        isos_cnt_q, isos_cnt_d;
    logic               irq_q, irq_d;
    logic               out_vld_q, out_isos_q;
    logic [63:0]        out_data_q;
    logic               active, beat_end, cw_failed, win_close;

    always_comb begin
        active       = rs_ena && (state_q != ST_IDLE);
        beat_end     = active && bus.dec_vld && (beat_q == BEAT_W'(WORDS_PER_CW - 1));
        cw_failed    = beat_end && (cw_fail_q || bus.rde_error);
        win_close    = beat_end && !clr_stats && (win_cw_q == WCW_W'(WIN_CW - 1));
        win_fail_nxt = win_fail_q;
        if (cw_failed && (win_fail_q != WFL_W'(FAIL_TH)))
            win_fail_nxt = win_fail_q + WFL_W'(1);

        beat_d     = beat_q;
        cw_fail_d  = cw_fail_q;
        win_cw_d   = win_cw_q;
        win_fail_d = win_fail_q;
        cw_cnt_d   = cw_cnt_q;
        fail_cnt_d = fail_cnt_q;
        isos_cnt_d = isos_cnt_q;
        if (!active) begin
            beat_d     = '0;
            cw_fail_d  = 1'b0;
            win_cw_d   = '0;
            win_fail_d = '0;
        end else begin
            if (bus.dec_vld)
                beat_d = beat_end ? '0 : beat_q + BEAT_W'(1);
            // An error on the ending beat belongs to that codeword; the flag restarts clean.
            cw_fail_d = beat_end ? 1'b0 : (cw_fail_q || bus.rde_error);
            if (beat_end) begin
                win_cw_d   = win_close ? '0 : win_cw_q + WCW_W'(1);
                win_fail_d = win_close ? '0 : win_fail_nxt;
            end
            cw_cnt_d   = sat_inc32(cw_cnt_q, beat_end);
            fail_cnt_d = sat_inc16(fail_cnt_q, cw_failed);
            isos_cnt_d = sat_inc16(isos_cnt_q, bus.dec_vld && bus.dec_isos);
        end

        clean_d = '0;
        if (active && (state_q == ST_DEGR)) begin
            clean_d = clean_q;
            if (win_close)
                clean_d = ((win_fail_nxt == '0) && (clean_q != CLN_W'(RECOVER_WIN - 1)))
                          ? clean_q + CLN_W'(1) : '0;
        end

        if (clr_stats) begin
            beat_d     = '0;
            cw_fail_d  = 1'b0;
            win_cw_d   = '0;
            win_fail_d = '0;
            cw_cnt_d   = '0;
            fail_cnt_d = '0;
            isos_cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_MON;
            ST_MON:  if (win_close && (win_fail_nxt >= WFL_W'(FAIL_TH))) state_d = ST_DEGR;
            ST_DEGR: begin
                if (win_close && (win_fail_nxt >= WFL_W'(FAIL_TH)))
                    state_d = ST_FAIL;
                else if (win_close && (win_fail_nxt == '0) && (clean_q == CLN_W'(RECOVER_WIN - 1)))
                    state_d = ST_MON;
            end
            ST_FAIL: if (clr_stats) state_d = ST_MON;
        endcase
        if (!rs_ena)
            state_d = ST_IDLE;
        irq_d = (state_d == ST_FAIL) && (state_q != ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            cw_fail_q  <= 1'b0;
            win_cw_q   <= '0;
            win_fail_q <= '0;
            clean_q    <= '0;
            cw_cnt_q   <= '0;
            fail_cnt_q <= '0;
            isos_cnt_q <= '0;
            irq_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_isos_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cw_fail_q  <= cw_fail_d;
            win_cw_q   <= win_cw_d;
            win_fail_q <= win_fail_d;
            clean_q    <= clean_d;
            cw_cnt_q   <= cw_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            isos_cnt_q <= isos_cnt_d;
            irq_q      <= irq_d;
            out_vld_q  <= bus.dec_vld;
            if (bus.dec_vld) begin
                out_data_q <= bus.dec_data;
                out_isos_q <= bus.dec_isos;
            end
        end
    end

    always_comb begin
        link_state    = state_q;
        link_degrade  = (state_q == ST_DEGR) || (state_q == ST_FAIL);
        link_fail_irq = irq_q;
        cw_cnt        = cw_cnt_q;
        fail_cnt      = fail_cnt_q;
        isos_cnt      = isos_cnt_q;
        bus.out_vld   = out_vld_q;
        bus.out_data  = out_data_q;
        bus.out_isos  = out_isos_q;
    end
endmodule

// File: tb/tb_rs_dec_mon.sv
// Directed bench for rs_dec_mon: passthrough table, codeword/window sequences,
// clear/reset corner cases and counter saturation on a one-beat-codeword instance.
module tb_rs_dec_mon;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, rs_ena, clr_stats;
    logic [31:0] cw_cnt;
    logic [15:0] fail_cnt, isos_cnt;
    logic [1:0]  link_state;
    logic        link_degrade, link_fail_irq;

    logic        rs_ena2, clr_stats2;
    logic [31:0] cw_cnt2;
    logic [15:0] fail_cnt2, isos_cnt2;
    logic [1:0]  link_state2;
    logic        link_degrade2, link_fail_irq2;

    rs_dec_mon_if bus();
    rs_dec_mon_if bus2();

    rs_dec_mon #(.WORDS_PER_CW(24), .WIN_CW(8), .FAIL_TH(2), .RECOVER_WIN(2)) dut (
        .clk(clk), .rstn(rstn), .rs_ena(rs_ena), .clr_stats(clr_stats), .bus(bus),
        .cw_cnt(cw_cnt), .fail_cnt(fail_cnt), .isos_cnt(isos_cnt), .link_state(link_state),
        .link_degrade(link_degrade), .link_fail_irq(link_fail_irq)
    );

    rs_dec_mon #(.WORDS_PER_CW(1), .WIN_CW(4), .FAIL_TH(1), .RECOVER_WIN(1)) dut2 (
        .clk(clk), .rstn(rstn), .rs_ena(rs_ena2), .clr_stats(clr_stats2), .bus(bus2),
        .cw_cnt(cw_cnt2), .fail_cnt(fail_cnt2), .isos_cnt(isos_cnt2), .link_state(link_state2),
        .link_degrade(link_degrade2), .link_fail_irq(link_fail_irq2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int irq_cycles = 0;

    always @(negedge clk) if (link_fail_irq) irq_cycles++;

    typedef struct {
        logic        ena;
        logic        vld;
        logic [63:0] data;
        logic        isos;
        logic        e_vld;
        logic [63:0] e_data;
        logic        e_isos;
        logic [15:0] e_icnt;
    } pt_vec_t;

    pt_vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic err);
        bus.dec_vld   = 1'b1;
        bus.dec_data  = d;
        bus.dec_isos  = 1'b0;
        bus.rde_error = err;
        step();
        bus.dec_vld   = 1'b0;
        bus.rde_error = 1'b0;
    endtask

    task automatic cw(input int err_beat);
        for (int b = 0; b < 24; b++) beat(64'(b), b == err_beat);
    endtask

    task automatic window(input logic [7:0] mask);
        for (int c = 0; c < 8; c++) cw(mask[c] ? 7 : -1);
    endtask

    task automatic clr_pulse();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; rs_ena = 1'b1; clr_stats = 1'b0;
        rs_ena2 = 1'b0; clr_stats2 = 1'b0;
        bus.dec_vld = 1'b1; bus.dec_data = 64'hCAFE; bus.dec_isos = 1'b1; bus.rde_error = 1'b1;
        bus2.dec_vld = 1'b0; bus2.dec_data = '0; bus2.dec_isos = 1'b0; bus2.rde_error = 1'b0;

        tbl[0] = '{1'b0, 1'b1, 64'h1111,              1'b1, 1'b1, 64'h1111,              1'b1, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 64'hAAAA,              1'b1, 1'b1, 64'hAAAA,              1'b1, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 64'hDEAD,              1'b1, 1'b0, 64'hAAAA,              1'b1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 64'h5555,              1'b1, 1'b1, 64'h5555,              1'b1, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 64'h0,                 1'b0, 1'b1, 64'h0,                 1'b0, 16'd1};
        tbl[5] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 1'b0, 64'h1234,              1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'd1};

        // Reset state with activity on the inputs
        repeat (3) step();
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_isos", bus.out_isos, 0);
        check("rst_cw_cnt", cw_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_isos_cnt", isos_cnt, 0);
        check("rst_state", link_state, 0);
        check("rst_degrade", link_degrade, 0);
        check("rst_irq", link_fail_irq, 0);
        rstn = 1'b1; rs_ena = 1'b0;
        bus.dec_vld = 1'b0; bus.dec_isos = 1'b0; bus.rde_error = 1'b0;
        step();

        // Passthrough table, including IDLE and hold cases
        for (int i = 0; i < 7; i++) begin
            rs_ena       = tbl[i].ena;
            bus.dec_vld  = tbl[i].vld;
            bus.dec_data = tbl[i].data;
            bus.dec_isos = tbl[i].isos;
            step();
            check($sformatf("pt%0d_vld", i), bus.out_vld, tbl[i].e_vld);
            check($sformatf("pt%0d_data", i), bus.out_data, tbl[i].e_data);
            check($sformatf("pt%0d_isos", i), bus.out_isos, tbl[i].e_isos);
            check($sformatf("pt%0d_isos_cnt", i), isos_cnt, tbl[i].e_icnt);
        end
        check("tbl_end_state", link_state, 0);
        bus.dec_vld = 1'b0; bus.dec_isos = 1'b0;
        clr_pulse();
        check("clr_isos_cnt", isos_cnt, 0);

        // Two clean codewords with 1-cycle passthrough
        rs_ena = 1'b1;
        step();
        check("mon_entry", link_state, 1);
        for (int k = 0; k < 48; k++) begin
            logic [63:0] d;
            d = 64'h0123_4567_0000_0000 | 64'(k * 7919);
            beat(d, 1'b0);
            check("pt48_data", bus.out_data, d);
        end
        check("cw48_cw_cnt", cw_cnt, 2);
        check("cw48_fail_cnt", fail_cnt, 0);
        check("cw48_state", link_state, 1);

        // Windows: degrade, recovery, fail
        clr_pulse();
        for (int c = 0; c < 7; c++) cw((c == 1 || c == 5) ? 7 : -1);
        check("w1_pre_close", link_state, 1);
        cw(-1);
        check("w1_degr", link_state, 2);
        check("w1_degrade_flag", link_degrade, 1);
        window(8'h00);
        check("w2_clean", link_state, 2);
        window(8'h01);
        check("w3_onefail", link_state, 2);
        window(8'h00);
        check("w4_clean", link_state, 2);
        window(8'h00);
        check("w5_recover", link_state, 1);
        check("w5_degrade_flag", link_degrade, 0);
        window(8'h81);
        check("w6_degr", link_state, 2);
        window(8'h0C);
        check("w7_fail", link_state, 3);
        check("w7_irq", link_fail_irq, 1);
        step();
        check("w7_irq_drop", link_fail_irq, 0);
        window(8'h00);
        check("w8_sticky", link_state, 3);
        window(8'hFF);
        check("w9_sticky", link_state, 3);
        check("irq_once", irq_cycles, 1);
        check("win_cw_cnt", cw_cnt, 72);
        check("win_fail_cnt", fail_cnt, 15);
        clr_pulse();
        check("fail_exit_state", link_state, 1);
        check("fail_exit_cw", cw_cnt, 0);
        check("fail_exit_fail", fail_cnt, 0);

        // rde_error on the ending beat together with clr_stats
        for (int b = 0; b < 23; b++) beat(64'(b), 1'b0);
        bus.dec_vld = 1'b1; bus.rde_error = 1'b1; clr_stats = 1'b1;
        bus.dec_data = 64'hBEEF;
        step();
        bus.dec_vld = 1'b0; bus.rde_error = 1'b0; clr_stats = 1'b0;
        check("clrwin_cw", cw_cnt, 0);
        check("clrwin_fail", fail_cnt, 0);
        check("clrwin_pt", bus.out_data, 64'hBEEF);
        cw(23);
        check("endfail_cw", cw_cnt, 1);
        check("endfail_fail", fail_cnt, 1);
        cw(-1);
        check("sticky_clear_cw", cw_cnt, 2);
        check("sticky_clear_fail", fail_cnt, 1);

        // rs_ena drop mid-codeword discards the partial codeword
        for (int b = 0; b < 10; b++) beat(64'(b), 1'b0);
        rs_ena = 1'b0;
        beat(64'd10, 1'b0);
        check("ena_low_idle", link_state, 0);
        rs_ena = 1'b1;
        step();
        for (int b = 0; b < 23; b++) beat(64'(b), 1'b0);
        check("ena_partial_cw", cw_cnt, 2);
        beat(64'd23, 1'b0);
        check("ena_full_cw", cw_cnt, 3);

        // Reset mid-codeword
        for (int b = 0; b < 5; b++) beat(64'(b), 1'b0);
        rstn = 1'b0; bus.dec_vld = 1'b1;
        step();
        bus.dec_vld = 1'b0;
        check("midrst_out_vld", bus.out_vld, 0);
        check("midrst_cw", cw_cnt, 0);
        check("midrst_state", link_state, 0);
        rstn = 1'b1;
        step();
        for (int b = 0; b < 23; b++) beat(64'(b), 1'b0);
        check("midrst_partial", cw_cnt, 0);
        beat(64'd23, 1'b0);
        check("midrst_full", cw_cnt, 1);

        // Saturation on a one-beat-codeword instance
        rs_ena2 = 1'b1;
        step();
        bus2.dec_vld = 1'b1; bus2.rde_error = 1'b1; bus2.dec_isos = 1'b1;
        repeat (65535) step();
        check("sat_fail_reach", fail_cnt2, 16'hFFFF);
        check("sat_isos_reach", isos_cnt2, 16'hFFFF);
        check("sat_cw_reach", cw_cnt2, 65535);
        repeat (3) step();
        check("sat_fail_hold", fail_cnt2, 16'hFFFF);
        check("sat_isos_hold", isos_cnt2, 16'hFFFF);
        check("sat_cw_count", cw_cnt2, 65538);
        bus2.dec_vld = 1'b0; bus2.rde_error = 1'b0; bus2.dec_isos = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
